datapath_unit: RTL and testbench
================================

Name: datapath_unit

Overview:
- 4-bit register/ALU datapath driven entirely by an external controller through mux selects, load enables and an ALU opcode.
- Holds three registers: R1 (operand), ACC (accumulator, drives `out`) and Q (bidirectional shift register coupled to ACC).
- Used as the execution core beneath a small control FSM for arithmetic/logic sequences, e.g. shift-and-add style algorithms.

Parameters:
- WIDTH, 4, data width of `in`, `out`, R1, ACC, Q and the ALU.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all registers.
- mux_2x1_R1_sel  input  1  R1 next-value select: 0 = load `in`, 1 = hold.
- mux_2x1_alu_a_sel  input  1  ALU operand A select: 0 = ACC, 1 = Q.
- mux_2x1_acc_sel  input  1  ACC data select: 0 = ALU result, 1 = `in`.
- acc_load_sel  input  1  1 = ACC loads the selected data; 0 = ACC holds.
- q_dir_sel  input  1  Q shift direction: 0 = left, 1 = right.
- alu_control  input  3  ALU opcode.
- in  input  WIDTH  external data input.
- out  output  WIDTH  equals ACC (registered, no combinational path from inputs).

Behaviour:
- Interface: one clock `clk`; reset `reset` is asynchronous and active-high.
- While `reset`=1: R1 = 0, ACC = 0, Q = 0, so out = 0. Takes effect immediately, independent of `clk`, including mid-sequence.
- All register updates occur on the rising edge of `clk`. Selects sampled at that edge are applied at that edge; the result is visible on `out` after the edge (1-cycle latency).
- R1:
  - sel=0: R1 <= in.
  - sel=1: R1 <= R1.
- ALU (combinational): A = alu_a_sel ? Q : ACC; B = R1. Results are WIDTH bits, wrap modulo 2^WIDTH, no flags or carry out.
  - 000: A+B
  - 001: A-B (two's complement)
  - 010: A&B
  - 011: A|B
  - 100: A^B
  - 101: ~A
  - 110: A (pass)
  - 111: B (pass)
- ACC:
  - acc_load_sel=1: ACC <= (mux_2x1_acc_sel ? in : alu_result).
  - acc_load_sel=0: ACC holds.
- Q shifts on every clock edge (no hold mode):
  - q_dir_sel=0: Q <= {Q[WIDTH-2:0], ACC[WIDTH-1]}.
  - q_dir_sel=1: Q <= {ACC[0], Q[WIDTH-1:1]}.
- Simultaneous updates: when ACC loads and Q shifts in the same edge, Q uses the pre-edge ACC value. When the ALU reads R1 or Q in the same cycle they update, it uses the pre-edge values.
- No X propagation from unused paths; all selects are fully decoded.

Decomposition:
- Shared package: ALU opcode constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT, ALU_PASSA, ALU_PASSB) and the WIDTH default.
- One natural sub-module: `alu_unit` (combinational, A/B/opcode -> result).
- Registers and muxes live in the top module.

Test Plan:
- Reset: set registers nonzero, assert reset between clock edges -> out = 0 immediately; Q = 0 and R1 = 0 after release.
- Load and hold:
  - in=0101, R1_sel=0, acc_sel=1, acc_load=1, one edge -> out = 0101.
  - Then acc_load=0, in=1111 -> out stays 0101.
- ADD with wrap: ACC=1010, R1=0111, alu_a_sel=0, op=000, acc_sel=0, acc_load=1 -> out = 0001.
- SUB/logic: ACC=0011, R1=0101, then sequentially:
  - op=001 -> out = 1110.
  - Reload ACC=0011, op=010 -> out = 0001.
  - Reload ACC=0011, op=100 -> out = 0110.
- Q shift:
  - Reset, ACC=1001, q_dir=0 for 2 edges -> Q = 0011.
  - Then alu_a_sel=1, op=110, acc_load=1 -> out = 0011.
  - q_dir=1 with ACC[0]=1 -> Q MSB fills with 1.
- Hold R1: load R1=0010, R1_sel=1, change in to 1111, ACC=0000, op=111 -> out = 0010.

Source files
------------

// File: rtl/datapath_unit_pkg.sv
// Shared definitions for the datapath unit: default data width and ALU opcodes.
package datapath_unit_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_OR    = 3'b011,
        ALU_XOR   = 3'b100,
        ALU_NOT   = 3'b101,
        ALU_PASSA = 3'b110,
        ALU_PASSB = 3'b111
    } alu_op_t;

endpackage

// File: rtl/datapath_unit_alu.sv
// Combinational ALU: WIDTH-bit result, wraps modulo 2^WIDTH, no flags.
module alu_unit
    import datapath_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = a ^ b;
            ALU_NOT:   result = ~a;
            ALU_PASSA: result = a;
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/datapath_unit.sv
// Register/ALU datapath: operand register R1, accumulator ACC and shift register Q,
// all steered by an external controller.
module datapath_unit
    import datapath_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mux_2x1_R1_sel,
    input  logic             mux_2x1_alu_a_sel,
    input  logic             mux_2x1_acc_sel,
    input  logic             acc_load_sel,
    input  logic             q_dir_sel,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] r1;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] acc_next;

    assign alu_a    = mux_2x1_alu_a_sel ? q : acc;
    assign acc_next = mux_2x1_acc_sel ? in : alu_result;

    alu_unit #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (alu_a),
        .b      (r1),
        .op     (alu_control),
        .result (alu_result)
    );

    // Q shifts every edge and always takes its fill bit from the pre-edge ACC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r1  <= '0;
            acc <= '0;
            q   <= '0;
        end else begin
            if (!mux_2x1_R1_sel)
                r1 <= in;
            if (acc_load_sel)
                acc <= acc_next;
            if (q_dir_sel)
                q <= {acc[0], q[WIDTH-1:1]};
            else
                q <= {q[WIDTH-2:0], acc[WIDTH-1]};
        end
    end

    assign out = acc;

endmodule

// File: tb/tb_datapath_unit.sv
// Bench for datapath_unit: directed scenarios plus random traffic against an arithmetic reference model.
module tb_datapath_unit;

    localparam int W = 4;
    localparam int M = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         r1_sel = 1'b0;
    logic         a_sel = 1'b0;
    logic         acc_sel = 1'b0;
    logic         load = 1'b0;
    logic         qdir = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] din = '0;
    logic [W-1:0] dout;

    int vectors = 0;
    int miscompares = 0;

    // reference state as plain integers
    int m_r1 = 0;
    int m_acc = 0;
    int m_q = 0;

    datapath_unit #(.WIDTH(W)) dut (
        .clk               (clk),
        .reset             (reset),
        .mux_2x1_R1_sel    (r1_sel),
        .mux_2x1_alu_a_sel (a_sel),
        .mux_2x1_acc_sel   (acc_sel),
        .acc_load_sel      (load),
        .q_dir_sel         (qdir),
        .alu_control       (op),
        .in                (din),
        .out               (dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int alu_ref(input int o, input int a, input int b);
        case (o)
            0: return (a + b) % M;
            1: return (a - b + M) % M;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return (M - 1) - a;
            6: return a;
            default: return b;
        endcase
    endfunction

    // One clock edge: model computed from pre-edge state and inputs, then out checked.
    task automatic step(input string tag);
        int a, res, n_r1, n_acc, n_q, msb, lsb;
        a     = a_sel ? m_q : m_acc;
        res   = alu_ref(int'(op), a, m_r1);
        n_r1  = r1_sel ? m_r1 : int'(din);
        n_acc = load ? (acc_sel ? int'(din) : res) : m_acc;
        msb   = m_acc / (M / 2);
        lsb   = m_acc % 2;
        n_q   = qdir ? (m_q / 2 + lsb * (M / 2)) : ((m_q * 2) % M + msb);
        @(posedge clk);
        #1;
        m_r1  = n_r1;
        m_acc = n_acc;
        m_q   = n_q;
        chk(tag, int'(dout), m_acc);
    endtask

    task automatic set(input logic rs, input logic as, input logic cs, input logic ld,
                       input logic qd, input int o, input int d);
        r1_sel  = rs;
        a_sel   = as;
        acc_sel = cs;
        load    = ld;
        qdir    = qd;
        op      = 3'(o);
        din     = W'(d);
    endtask

    task automatic model_clear();
        m_r1  = 0;
        m_acc = 0;
        m_q   = 0;
    endtask

    // reset raised between edges, held over one edge, released after it
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        chk(tag, int'(dout), 0);
        @(posedge clk);
        #1;
        chk(tag, int'(dout), 0);
        reset = 1'b0;
    endtask

    initial begin
        // reset state
        @(posedge clk);
        #1;
        chk("reset_out", int'(dout), 0);
        reset = 1'b0;

        // load and hold
        set(0, 0, 1, 1, 0, 0, 5);   step("load_in");  chk("load_0101", int'(dout), 5);
        set(0, 0, 1, 0, 0, 0, 15);  step("hold_acc"); chk("hold_0101", int'(dout), 5);

        // ADD with wrap: 1010 + 0111
        set(0, 0, 0, 0, 0, 0, 7);   step("ld_r1_7");
        set(1, 0, 1, 1, 0, 0, 10);  step("ld_acc_10");
        set(1, 0, 0, 1, 0, 0, 0);   step("add");      chk("add_wrap", int'(dout), 1);

        // SUB / AND / XOR with ACC=0011, R1=0101
        set(0, 0, 0, 0, 0, 0, 5);   step("ld_r1_5");
        set(1, 0, 1, 1, 0, 0, 3);   step("ld_acc_3");
        set(1, 0, 0, 1, 0, 1, 0);   step("sub");      chk("sub_1110", int'(dout), 14);
        set(1, 0, 1, 1, 0, 0, 3);   step("reload_a");
        set(1, 0, 0, 1, 0, 2, 0);   step("and");      chk("and_0001", int'(dout), 1);
        set(1, 0, 1, 1, 0, 0, 3);   step("reload_b");
        set(1, 0, 0, 1, 0, 4, 0);   step("xor");      chk("xor_0110", int'(dout), 6);

        // Q shift left twice from ACC=1001, then read Q through the ALU
        async_reset("rst_mid_seq");
        set(1, 0, 1, 1, 0, 0, 9);   step("ld_acc_9");
        set(1, 0, 0, 0, 0, 0, 0);   step("shl_1");
        step("shl_2");
        set(1, 1, 0, 1, 0, 6, 0);   step("read_q");   chk("q_0011", int'(dout), 3);
        // ACC is now 0011: right shift fills Q MSB with ACC[0]=1 -> Q = 1011
        set(1, 0, 0, 0, 1, 0, 0);   step("shr");
        set(1, 1, 0, 1, 1, 6, 0);   step("read_q2");  chk("q_msb_fill", int'(dout), 11);

        // R1 hold while in changes
        set(0, 0, 0, 0, 0, 0, 2);   step("ld_r1_2");
        set(1, 0, 1, 1, 0, 0, 0);   step("acc_zero");
        set(1, 0, 0, 1, 0, 7, 15);  step("passb");    chk("r1_hold", int'(dout), 2);

        // randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                async_reset("rand_reset");
            end else begin
                set(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, M - 1)));
                step("rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
